// File: rtl/riscv_defs.sv
// rtl/riscv_defs.sv - shared RV32I opcode, register and hazard FSM definitions
//
// Purpose: constants shared by the hazard control slice.
// Contents: base opcodes, the x0 register index and the hazard FSM state encoding.
package riscv_defs;

  localparam logic [6:0] RTYPE = 7'b0110011;
  localparam logic [6:0] ITYPE = 7'b0010011;
  localparam logic [6:0] ILOAD = 7'b0000011;
  localparam logic [6:0] IJALR = 7'b1100111;
  localparam logic [6:0] BTYPE = 7'b1100011;
  localparam logic [6:0] STYPE = 7'b0100011;
  localparam logic [6:0] JTYPE = 7'b1101111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] UTYPE = 7'b0110111;

  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'b00,
    HZ_MEM_WAIT = 2'b01,
    HZ_TIMEOUT  = 2'b10
  } hz_state_t;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - load-use hazard detection for the decode stage
//
// Purpose: flags a decode instruction that reads the register a load in EX writes.
// Ports:
//   id_opcode, id_rs1, id_rs2 : instruction in decode
//   ex_rd, ex_mem_read        : destination and load flag of the instruction in EX
//   load_use                  : decode must wait one cycle for the load data
module load_use_detect
  import riscv_defs::*;
(
  input  logic [6:0] id_opcode,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       load_use
);

  logic uses_rs1;
  logic uses_rs2;

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (id_opcode)
      RTYPE, BTYPE, STYPE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      ITYPE, ILOAD, IJALR: uses_rs1 = 1'b1;
      default: ;
    endcase
  end

  // x0 is never a real dependency: writes to it are discarded.
  assign load_use = ex_mem_read && (ex_rd != ZERO_REG) &&
                    ((uses_rs1 && (ex_rd == id_rs1)) || (uses_rs2 && (ex_rd == id_rs2)));

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush control for the 5-stage RV32I pipeline
//
// Purpose: load-use stalls, mispredict squashes, data-memory freeze with a
//          timeout watchdog, and stall/flush performance counters.
// Ports:
//   clk, rst (async, active low)
//   id_opcode, id_rs1, id_rs2, ex_rd, ex_mem_read : hazard sources
//   ex_mispredict, mem_req, dmem_ready           : redirect and memory handshake
//   pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, id_flush, id_ex_flush
//   mem_timeout_err                              : sticky until reset
//   stall_cycles, flush_count                    : wrapping perf counters
module hazard_ctrl
  import riscv_defs::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int WAIT_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_mispredict,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_mem_stall,
  output logic             id_flush,
  output logic             id_ex_flush,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  hz_state_t         state, next_state;
  logic [WAIT_W-1:0] wait_cnt, next_wait;
  logic              freeze;
  logic              load_use;

  load_use_detect u_load_use_detect (
    .id_opcode   (id_opcode),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= HZ_RUN;
      wait_cnt     <= '0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_wait;
      if (pc_stall) stall_cycles <= stall_cycles + CNT_W'(1);
      if (id_flush) flush_count  <= flush_count + CNT_W'(1);
    end
  end

  always_comb begin
    next_state   = state;
    next_wait    = wait_cnt;
    freeze       = 1'b0;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    id_flush     = 1'b0;
    id_ex_flush  = 1'b0;

    case (state)
      HZ_RUN: begin
        freeze = mem_req && !dmem_ready;
        if (freeze) begin
          next_state = HZ_MEM_WAIT;
          next_wait  = WAIT_W'(1);
        end
      end
      HZ_MEM_WAIT: begin
        freeze = !dmem_ready;
        if (dmem_ready) begin
          next_state = HZ_RUN;
          next_wait  = '0;
        end else begin
          // wait_cnt counts not-ready cycles including the entry cycle, so
          // reaching MEM_TIMEOUT means MEM_TIMEOUT consecutive misses.
          next_wait = wait_cnt + WAIT_W'(1);
          if (next_wait == WAIT_W'(MEM_TIMEOUT)) next_state = HZ_TIMEOUT;
        end
      end
      HZ_TIMEOUT: freeze = 1'b1;
      default: begin
        next_state = HZ_RUN;
        next_wait  = '0;
      end
    endcase

    // Outputs are Mealy on live inputs, so they must be masked while in reset.
    if (!rst) begin
      freeze = 1'b0;
    end else if (freeze) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
    end else if (ex_mispredict) begin
      // The dependent instruction is squashed, so a load-use stall is moot.
      id_flush    = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  assign mem_timeout_err = (state == HZ_TIMEOUT);

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  id_opcode = '0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic        ex_mem_read = 1'b0, ex_mispredict = 1'b0, mem_req = 1'b0, dmem_ready = 1'b1;
  logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, id_flush, id_ex_flush;
  logic        mem_timeout_err;
  logic [31:0] stall_cycles, flush_count;

  int n_checks = 0;
  int n_fail   = 0;

  // reference state: consecutive frozen cycles, timeout flag, counters
  int          m_nr = 0;
  bit          m_to = 0;
  logic [31:0] m_stall = '0, m_flush = '0;

  localparam logic [6:0] O_R = 7'b0110011, O_I = 7'b0010011, O_L = 7'b0000011,
                         O_JR = 7'b1100111, O_B = 7'b1100011, O_S = 7'b0100011,
                         O_J = 7'b1101111, O_A = 7'b0010111, O_U = 7'b0110111,
                         O_SYS = 7'b1110011;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mispredict(ex_mispredict),
    .mem_req(mem_req), .dmem_ready(dmem_ready), .pc_stall(pc_stall),
    .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall),
    .id_flush(id_flush), .id_ex_flush(id_ex_flush), .mem_timeout_err(mem_timeout_err),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit reads_rs1(input logic [6:0] op);
    return op inside {O_R, O_I, O_L, O_JR, O_B, O_S};
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return op inside {O_R, O_B, O_S};
  endfunction

  task automatic check_all(input logic [5:0] e_ctl, input bit e_err);
    chk("pc_stall",     {31'd0, pc_stall},     {31'd0, e_ctl[5]});
    chk("if_id_stall",  {31'd0, if_id_stall},  {31'd0, e_ctl[4]});
    chk("id_ex_stall",  {31'd0, id_ex_stall},  {31'd0, e_ctl[3]});
    chk("ex_mem_stall", {31'd0, ex_mem_stall}, {31'd0, e_ctl[2]});
    chk("id_flush",     {31'd0, id_flush},     {31'd0, e_ctl[1]});
    chk("id_ex_flush",  {31'd0, id_ex_flush},  {31'd0, e_ctl[0]});
    chk("timeout_err",  {31'd0, mem_timeout_err}, {31'd0, e_err});
    chk("stall_cycles", stall_cycles, m_stall);
    chk("flush_count",  flush_count,  m_flush);
  endtask

  // Called just after a rising edge; drives inputs, checks before the next edge.
  task automatic cycle(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input bit mr, input bit mp, input bit mq,
                       input bit rdy);
    bit ld, frz;
    logic [5:0] e;
    id_opcode = op; id_rs1 = r1; id_rs2 = r2; ex_rd = rd;
    ex_mem_read = mr; ex_mispredict = mp; mem_req = mq; dmem_ready = rdy;
    ld  = mr && rd != 0 && ((reads_rs1(op) && rd == r1) || (reads_rs2(op) && rd == r2));
    frz = m_to || (!rdy && (mq || m_nr > 0));
    if (frz)     e = 6'b111100;
    else if (mp) e = 6'b000011;
    else if (ld) e = 6'b110001;
    else         e = 6'b000000;
    #2;
    check_all(e, m_to);
    @(posedge clk);
    #1;
    if (e[5]) m_stall = m_stall + 1;
    if (e[1]) m_flush = m_flush + 1;
    if (!m_to) begin
      if (frz) begin
        m_nr++;
        if (m_nr == 16) m_to = 1;
      end else m_nr = 0;
    end
  endtask

  // Asserts reset between edges and checks it takes effect with no clock edge.
  task automatic do_reset();
    rst = 1'b0;
    m_nr = 0; m_to = 0; m_stall = '0; m_flush = '0;
    #2;
    check_all(6'b000000, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [6:0] ops [10];
    ops = '{O_R, O_I, O_L, O_JR, O_B, O_S, O_J, O_A, O_U, O_SYS};

    #1;
    do_reset();

    // load-use on rs1, then ex_rd=0 and UTYPE variants
    cycle(O_R, 5'd5, 5'd0, 5'd5, 1, 0, 0, 1);
    cycle(O_R, 5'd5, 5'd0, 5'd5, 0, 0, 0, 1);
    cycle(O_R, 5'd0, 5'd0, 5'd0, 1, 0, 0, 1);
    cycle(O_U, 5'd5, 5'd0, 5'd5, 1, 0, 0, 1);
    // STYPE rs2 match, JTYPE no match
    cycle(O_S, 5'd3, 5'd7, 5'd7, 1, 0, 0, 1);
    cycle(O_J, 5'd3, 5'd7, 5'd7, 1, 0, 0, 1);
    // mispredict overrides load-use
    cycle(O_R, 5'd5, 5'd0, 5'd5, 1, 1, 0, 1);

    // memory wait with held mispredict
    do_reset();
    repeat (3) cycle(O_I, 5'd1, 5'd2, 5'd9, 0, 1, 1, 0);
    cycle(O_I, 5'd1, 5'd2, 5'd9, 0, 1, 1, 1);
    chk("wait_stall_total", stall_cycles, 32'd3);
    chk("wait_flush_total", flush_count, 32'd1);

    // timeout: 16 not-ready cycles, then sticky even when ready
    do_reset();
    repeat (16) cycle(O_R, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0);
    repeat (3) cycle(O_R, 5'd1, 5'd2, 5'd3, 0, 1, 1, 1);
    do_reset();

    // async reset in the middle of a memory wait, then clean run
    repeat (2) cycle(O_B, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0);
    mem_req = 1'b1; dmem_ready = 1'b0;
    do_reset();
    cycle(O_B, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0);

    // randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 2) do_reset();
      else cycle(ops[$urandom_range(0, 9)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                 $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 40,
                 $urandom_range(0, 99) < 75);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
